// File: rtl/reg_file_pg.sv
// Parametrised register file: two combinational read ports, one write port, hardware clear
// sequencer, PC-keyed duplicate-write guard. Define RF_ZERO_REG_EN to hardwire entry 0 to zero.
module reg_file_pg #(
  parameter int unsigned DW     = 8,
  parameter int unsigned AW     = 4,
  parameter int unsigned PCW    = 12,
  parameter int unsigned BYPASS = 0
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           wr_en,
  input  logic [AW-1:0]  wr_addr,
  input  logic [DW-1:0]  dat_in,
  input  logic [PCW-1:0] prog_ctr,
  input  logic [AW-1:0]  rd_addrA,
  input  logic [AW-1:0]  rd_addrB,
  output logic [DW-1:0]  datA_out,
  output logic [DW-1:0]  datB_out,
  output logic           busy,
  output logic           wr_ack
);

  localparam int unsigned Depth   = 2 ** AW;
  localparam logic [AW:0] LastIdx = (AW + 1)'(Depth - 1);

  typedef enum logic {StClear, StRun} state_e;

  state_e         state_q, state_d;
  logic [AW:0]    clr_ptr_q, clr_ptr_d;
  logic           wr_ack_q, wr_ack_d;
  logic           pc_valid_q, pc_valid_d;
  logic [PCW-1:0] last_pc_q, last_pc_d;
  logic [DW-1:0]  mem_q [Depth];

  logic run, dup, accept, store;

  assign run    = (state_q == StRun);
  assign dup    = pc_valid_q && (prog_ctr == last_pc_q);
  assign accept = run && wr_en && !dup;

`ifdef RF_ZERO_REG_EN
  // Writes to entry 0 still count as accepted (ack, guard) but never reach storage.
  assign store = accept && (wr_addr != '0);
`else
  assign store = accept;
`endif

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    wr_ack_d   = 1'b0;
    pc_valid_d = pc_valid_q;
    last_pc_d  = last_pc_q;
    unique case (state_q)
      StClear: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LastIdx) state_d = StRun;
      end
      StRun: begin
        if (accept) begin
          wr_ack_d   = 1'b1;
          pc_valid_d = 1'b1;
          last_pc_d  = prog_ctr;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StClear;
      clr_ptr_q  <= '0;
      wr_ack_q   <= 1'b0;
      pc_valid_q <= 1'b0;
      last_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      wr_ack_q   <= wr_ack_d;
      pc_valid_q <= pc_valid_d;
      last_pc_q  <= last_pc_d;
    end
  end

  // Storage has no reset of its own; the clear sequencer zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (state_q == StClear) begin
        mem_q[clr_ptr_q[AW-1:0]] <= '0;
      end else if (store) begin
        mem_q[wr_addr] <= dat_in;
      end
    end
  end

  function automatic logic [DW-1:0] read_port(input logic [AW-1:0] addr);
    logic [DW-1:0] data;
    data = '0;
    if (run) begin
      data = mem_q[addr];
      if ((BYPASS != 0) && accept && (wr_addr == addr)) data = dat_in;
`ifdef RF_ZERO_REG_EN
      if (addr == '0) data = '0;
`endif
    end
    return data;
  endfunction

  always_comb begin
    datA_out = read_port(rd_addrA);
    datB_out = read_port(rd_addrB);
  end

  assign busy   = (state_q == StClear);
  assign wr_ack = wr_ack_q;

endmodule

// File: tb/tb_reg_file_pg.sv
// Self-checking bench for reg_file_pg: directed steps plus random traffic against a
// behavioural model; runs a BYPASS=0 and a BYPASS=1 instance side by side.
module tb_reg_file_pg;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned PCW   = 12;
  localparam int unsigned Depth = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  dat_in;
  logic [PCW-1:0] prog_ctr;
  logic [AW-1:0]  rd_addrA, rd_addrB;
  logic [DW-1:0]  datA_out, datB_out, bpA_out, bpB_out;
  logic           busy, wr_ack, bp_busy, bp_wr_ack;

  reg_file_pg #(.DW(DW), .AW(AW), .PCW(PCW), .BYPASS(0)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
    .prog_ctr(prog_ctr), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB), .datA_out(datA_out),
    .datB_out(datB_out), .busy(busy), .wr_ack(wr_ack)
  );

  reg_file_pg #(.DW(DW), .AW(AW), .PCW(PCW), .BYPASS(1)) dut_bp (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
    .prog_ctr(prog_ctr), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB), .datA_out(bpA_out),
    .datB_out(bpB_out), .busy(bp_busy), .wr_ack(bp_wr_ack)
  );

  // Reference model: clear countdown, contents array, guard and expected ack.
  logic [DW-1:0]  m_mem [Depth];
  int             m_left;
  bit             m_pcv;
  logic [PCW-1:0] m_pc;
  bit             m_ack;

  int n_vec = 0;
  int n_err = 0;
  int cnt;

  function automatic bit m_accept();
    return (m_left == 0) && wr_en && !(m_pcv && (prog_ctr == m_pc));
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a, input bit bp);
    if (m_left != 0) return '0;
`ifdef RF_ZERO_REG_EN
    if (a == '0) return '0;
`endif
    if (bp && m_accept() && (wr_addr == a)) return dat_in;
    return m_mem[a];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] d,
                       input logic [PCW-1:0] pc, input logic [AW-1:0] ra,
                       input logic [AW-1:0] rb);
    wr_en = we; wr_addr = wa; dat_in = d; prog_ctr = pc; rd_addrA = ra; rd_addrB = rb;
  endtask

  // One clock: check reads mid-cycle, advance model at the edge, check registered outputs.
  task automatic cycle(input bit chk);
    bit acc;
    #4;
    if (chk) begin
      check("rdA", datA_out, m_read(rd_addrA, 1'b0));
      check("rdB", datB_out, m_read(rd_addrB, 1'b0));
      check("bpA", bpA_out, m_read(rd_addrA, 1'b1));
      check("bpB", bpB_out, m_read(rd_addrB, 1'b1));
    end
    @(posedge clk);
    if (!reset_n) begin
      m_left = Depth; m_pcv = 1'b0; m_pc = '0; m_ack = 1'b0;
      foreach (m_mem[i]) m_mem[i] = '0;
    end else if (m_left > 0) begin
      m_left--; m_ack = 1'b0;
    end else begin
      acc = m_accept();
      m_ack = acc;
      if (acc) begin
        m_pcv = 1'b1; m_pc = prog_ctr;
`ifdef RF_ZERO_REG_EN
        if (wr_addr != '0) m_mem[wr_addr] = dat_in;
`else
        m_mem[wr_addr] = dat_in;
`endif
      end
    end
    #1;
    if (chk) begin
      check("busy", {31'b0, busy}, {31'b0, m_left > 0});
      check("wr_ack", {31'b0, wr_ack}, {31'b0, m_ack});
      check("bp_wr_ack", {31'b0, bp_wr_ack}, {31'b0, m_ack});
    end
  endtask

  initial begin
    m_left = Depth; m_pcv = 1'b0; m_pc = '0; m_ack = 1'b0;
    reset_n = 1'b0;
    drive(1'b0, '0, '0, '0, '0, '0);
    cycle(1'b0);
    cycle(1'b1);
    check("busy_in_reset", {31'b0, busy}, 32'd1);

    // Clear after release: busy for exactly Depth cycles, reads forced to zero.
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      drive(1'b1, AW'(i), 8'h5A, PCW'(i), AW'(i), AW'(15 - i));
      cycle(1'b1);
      cnt++;
    end
    check("clear_len", cnt, 32'd16);
    for (int i = 0; i < Depth; i++) begin
      drive(1'b0, '0, '0, '0, AW'(i), AW'(15 - i));
      #1;
      check("post_clear_zero", datA_out, 32'h0);
      cycle(1'b1);
    end

    // Write then read, no bypass.
    drive(1'b1, 4'd3, 8'hA5, 12'h010, 4'd3, 4'd0);
    cycle(1'b1);
    check("ack_a5", {31'b0, wr_ack}, 32'd1);
    drive(1'b0, '0, '0, 12'h010, 4'd3, 4'd3);
    #1;
    check("rd_a5", datA_out, 32'hA5);
    cycle(1'b1);

    // Duplicate guard.
    drive(1'b1, 4'd5, 8'h11, 12'h020, 4'd5, 4'd5);
    cycle(1'b1);
    check("dup_first_ack", {31'b0, wr_ack}, 32'd1);
    cycle(1'b1);
    check("dup_second_ack", {31'b0, wr_ack}, 32'd0);
    drive(1'b0, 4'd5, 8'h22, 12'h020, 4'd5, 4'd5);
    #1;
    check("dup_keep_11", datA_out, 32'h11);
    cycle(1'b1);
    drive(1'b1, 4'd5, 8'h22, 12'h021, 4'd5, 4'd5);
    cycle(1'b1);
    check("dup_third_ack", {31'b0, wr_ack}, 32'd1);
    drive(1'b0, '0, '0, 12'h021, 4'd5, 4'd5);
    #1;
    check("dup_r5_22", datB_out, 32'h22);
    cycle(1'b1);

    // Same-cycle bypass on both ports.
    drive(1'b1, 4'd7, 8'h3C, 12'h030, 4'd7, 4'd7);
    #1;
    check("bypass_A", bpA_out, 32'h3C);
    check("bypass_B", bpB_out, 32'h3C);
    check("nobypass_A", datA_out, 32'h00);
    cycle(1'b1);

    // Write to entry 0 at a fresh PC.
    drive(1'b1, 4'd0, 8'hFF, 12'h100, 4'd0, 4'd0);
    cycle(1'b1);
    check("r0_ack", {31'b0, wr_ack}, 32'd1);
    drive(1'b0, '0, '0, 12'h100, 4'd0, 4'd0);
    #1;
`ifdef RF_ZERO_REG_EN
    check("r0_read", datA_out, 32'h00);
`else
    check("r0_read", datA_out, 32'hFF);
`endif
    cycle(1'b1);

    // Random traffic with a narrow PC range so duplicates are frequent.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
            PCW'($urandom_range(0, 3)), AW'($urandom), AW'($urandom));
      cycle(1'b1);
    end

    // Reset re-asserted in the middle of a clear restarts it; writes during clear ignored.
    reset_n = 1'b0;
    drive(1'b0, '0, '0, '0, '0, '0);
    cycle(1'b1);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, AW'(i), 8'hC3, PCW'(i + 8), AW'(i), AW'(i));
      cycle(1'b1);
    end
    reset_n = 1'b0;
    cycle(1'b1);
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      drive(1'b1, AW'(i), 8'h96, PCW'(i + 64), AW'(i), AW'(i));
      cycle(1'b1);
      check("no_ack_in_clear", {31'b0, wr_ack}, 32'd0);
      cnt++;
    end
    check("restart_clear_len", cnt, 32'd16);
    for (int i = 0; i < Depth; i++) begin
      drive(1'b0, '0, '0, '0, AW'(i), AW'(i));
      #1;
      check("restart_zero", datB_out, 32'h0);
      cycle(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
